// File: rtl/mem_refresh_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mem_ctrl_pkg
//  Purpose  : Shared types and constants for the memory refresh/access
//             sequencer slice (FSM state encoding, default bus widths,
//             refresh counter width).
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package mem_ctrl_pkg;

  // Default widths used by the interface and the top-level controller.
  localparam int DEF_ADDR_W = 4;
  localparam int DEF_DATA_W = 16;

  // Width of the optional completed-refresh counter.
  localparam int REFRESH_COUNT_W = 16;

  // Sequencer states; the controller re-exports these as 2-bit localparams.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCESS  = 2'd1,
    ST_RD_WAIT = 2'd2,
    ST_REFRESH = 2'd3
  } state_e;

endpackage : mem_ctrl_pkg
`default_nettype wire

// File: rtl/mem_refresh_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : mem_refresh_ctrl_if
//  Purpose  : Bundles the system request/response handshake and the memory
//             macro port of the refresh controller.
//  Modports : slave  - the controller (accepts requests, drives the macro)
//             master - the system requester plus the memory macro model
//  Signals  : req_valid/req_write/req_addr/req_wdata/req_ready,
//             rsp_valid/rsp_rdata, mem_en/mem_we/mem_addr/mem_wdata/
//             mem_rdata/mem_refresh
//  Revision : 1.0  initial release
// ============================================================================
interface mem_refresh_ctrl_if
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);

  logic              req_valid;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              req_ready;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_refresh;

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata,
           mem_en, mem_we, mem_addr, mem_wdata, mem_refresh
  );

  modport master (
    output req_valid, req_write, req_addr, req_wdata, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata,
           mem_en, mem_we, mem_addr, mem_wdata, mem_refresh
  );

endinterface : mem_refresh_ctrl_if
`default_nettype wire

// File: rtl/mem_refresh_ctrl_edge.sv
`default_nettype none
// ============================================================================
//  Module   : refresh_edge_detect
//  Purpose  : Turns rising edges of the divider's refresh_clk into a pending
//             refresh request and flags requests that arrive while one is
//             still outstanding.
//  Ports    : clk, reset      - clock / synchronous active-high reset
//             enabled         - rises seen while low are discarded
//             refresh_clk     - divider square wave (synchronous to clk)
//             clear           - controller has started the pending refresh
//             pending         - a refresh is waiting to be serviced
//             overrun         - sticky: a rise hit an uncleared pending
//  Revision : 1.0  initial release
// ============================================================================
module refresh_edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic enabled,
  input  logic refresh_clk,
  input  logic clear,
  output logic pending,
  output logic overrun
);

  logic refresh_q;
  logic pending_q, pending_d;
  logic overrun_q, overrun_d;
  logic rise;

  assign rise = refresh_clk & ~refresh_q;

  always_comb begin
    pending_d = pending_q;
    overrun_d = overrun_q;
    // A new edge landing on a request the FSM is not consuming this cycle
    // means one refresh is lost.
    if (rise && enabled && pending_q && !clear) begin
      overrun_d = 1'b1;
    end
    if (clear) begin
      pending_d = 1'b0;
    end
    // Set wins over clear: an edge coinciding with the start of the previous
    // refresh becomes the next request.
    if (rise && enabled) begin
      pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      // The divider resets its output high, so start high to avoid a
      // phantom edge when reset releases.
      refresh_q <= 1'b1;
      pending_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      refresh_q <= refresh_clk;
      pending_q <= pending_d;
      overrun_q <= overrun_d;
    end
  end

  assign pending = pending_q;
  assign overrun = overrun_q;

endmodule : refresh_edge_detect
`default_nettype wire

// File: rtl/mem_refresh_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : mem_refresh_ctrl
//  Purpose  : Arbitrates row refreshes (one per refresh_clk rising edge) and
//             single-word system reads/writes onto one memory macro port.
//             Refresh has priority; an in-progress access always completes.
//  Ports    : clk, reset      - clock / synchronous active-high reset
//             enabled         - low blocks new operations
//             refresh_clk     - divider refresh output
//             bus (slave)     - request/response handshake + memory port
//             refresh_overrun - sticky lost-refresh flag
//             refresh_count   - completed refreshes, saturating
//                               (only with MEM_REFRESH_COUNT_EN defined)
//  Options  : `define MEM_REFRESH_COUNT_EN to add the refresh_count output.
//  Revision : 1.0  initial release
// ============================================================================
module mem_refresh_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ROWS        = 16,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int REFRESH_CYC = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic enabled,
  input  logic refresh_clk,
  mem_refresh_ctrl_if.slave bus,
  output logic refresh_overrun
`ifdef MEM_REFRESH_COUNT_EN
  ,
  output logic [REFRESH_COUNT_W-1:0] refresh_count
`endif
);

  localparam logic [1:0] IDLE    = ST_IDLE;
  localparam logic [1:0] ACCESS  = ST_ACCESS;
  localparam logic [1:0] RD_WAIT = ST_RD_WAIT;
  localparam logic [1:0] REFRESH = ST_REFRESH;

  localparam int CNT_W = (REFRESH_CYC > 1) ? $clog2(REFRESH_CYC) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(REFRESH_CYC - 1);
  localparam logic [ADDR_W-1:0] ROW_LAST = ADDR_W'(ROWS - 1);

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              write_q, write_d;
  logic [ADDR_W-1:0] row_ptr_q, row_ptr_d;
  logic [CNT_W-1:0]  cyc_cnt_q, cyc_cnt_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;

  logic pending;
  logic clear;
  logic req_ready;

  refresh_edge_detect u_edge (
    .clk         (clk),
    .reset       (reset),
    .enabled     (enabled),
    .refresh_clk (refresh_clk),
    .clear       (clear),
    .pending     (pending),
    .overrun     (refresh_overrun)
  );

  // Gated by reset so every output reads 0 while reset is held.
  assign req_ready = ~reset & (state_q == IDLE) & enabled & ~pending;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    write_d     = write_q;
    row_ptr_d   = row_ptr_q;
    cyc_cnt_d   = cyc_cnt_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    clear       = 1'b0;
    case (state_q)
      IDLE: begin
        if (pending && enabled) begin
          state_d   = REFRESH;
          clear     = 1'b1;
          cyc_cnt_d = '0;
        end else if (bus.req_valid && req_ready) begin
          state_d = ACCESS;
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          write_d = bus.req_write;
        end
      end
      ACCESS: begin
        state_d = write_q ? IDLE : RD_WAIT;
      end
      RD_WAIT: begin
        // Macro data is valid now; register it so the response is a clean
        // one-cycle pulse in the following cycle.
        rsp_valid_d = 1'b1;
        rsp_rdata_d = bus.mem_rdata;
        state_d     = IDLE;
      end
      REFRESH: begin
        if (cyc_cnt_q == CNT_LAST) begin
          cyc_cnt_d = '0;
          row_ptr_d = (row_ptr_q == ROW_LAST) ? '0 : row_ptr_q + 1'b1;
          state_d   = IDLE;
        end else begin
          cyc_cnt_d = cyc_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      write_q     <= 1'b0;
      row_ptr_q   <= '0;
      cyc_cnt_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      write_q     <= write_d;
      row_ptr_q   <= row_ptr_d;
      cyc_cnt_q   <= cyc_cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  // Memory port is a pure decode of the state, so it is quiet in IDLE and
  // mem_en / mem_refresh can never overlap.
  assign bus.req_ready   = req_ready;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_rdata   = rsp_rdata_q;
  assign bus.mem_en      = (state_q == ACCESS);
  assign bus.mem_we      = (state_q == ACCESS) & write_q;
  assign bus.mem_addr    = (state_q == ACCESS)  ? addr_q    :
                           (state_q == REFRESH) ? row_ptr_q : '0;
  assign bus.mem_wdata   = (state_q == ACCESS)  ? wdata_q   : '0;
  assign bus.mem_refresh = (state_q == REFRESH);

`ifdef MEM_REFRESH_COUNT_EN
  logic                       refresh_done;
  logic [REFRESH_COUNT_W-1:0] refresh_count_q;

  assign refresh_done = (state_q == REFRESH) && (cyc_cnt_q == CNT_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      refresh_count_q <= '0;
    end else if (refresh_done && (refresh_count_q != '1)) begin
      refresh_count_q <= refresh_count_q + 1'b1;
    end
  end

  assign refresh_count = refresh_count_q;
`endif

endmodule : mem_refresh_ctrl
`default_nettype wire

// File: tb/tb_mem_refresh_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_refresh_ctrl
//  Purpose  : Self-checking bench for mem_refresh_ctrl: reset state, divider
//             driven refresh cadence and row wrap, write/read latency with a
//             memory model, refresh-vs-request priority, overrun, and reset
//             during read wait / refresh.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mem_refresh_ctrl;

  localparam int AW         = 4;
  localparam int DW         = 16;
  localparam int ROWS       = 16;
  localparam int RC         = 4;
  localparam int DIV_PERIOD = 256;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic enabled = 1'b1;
  logic man_clk = 1'b1;
  logic div_en = 1'b0;
  logic [7:0] div_cnt;
  logic refresh_clk;
  logic refresh_overrun;
`ifdef MEM_REFRESH_COUNT_EN
  logic [15:0] refresh_count;
`endif

  always #5 clk = ~clk;

  // Behavioural clock divider: output resets high, rises every 256 clocks.
  always @(posedge clk) begin
    if (reset || !div_en) div_cnt <= 8'd0;
    else                  div_cnt <= div_cnt + 8'd1;
  end
  assign refresh_clk = div_en ? ~div_cnt[7] : man_clk;

  mem_refresh_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_refresh_ctrl #(
    .ROWS(ROWS), .ADDR_W(AW), .DATA_W(DW), .REFRESH_CYC(RC)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .enabled         (enabled),
    .refresh_clk     (refresh_clk),
    .bus             (bus),
    .refresh_overrun (refresh_overrun)
`ifdef MEM_REFRESH_COUNT_EN
    ,
    .refresh_count   (refresh_count)
`endif
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory macro model: read data valid the cycle after a read strobe.
  logic [DW-1:0] mem [0:15];
  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
      else            bus.mem_rdata     <= mem[bus.mem_addr];
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] outs();
    return {22'd0, bus.req_ready, bus.rsp_valid, bus.rsp_rdata, bus.mem_en,
            bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.mem_refresh,
            refresh_overrun};
  endfunction

  // Scoreboard of expected read responses: data and the cycle it must show.
  typedef struct {
    logic [DW-1:0] data;
    int            cyc;
  } rsp_t;
  rsp_t sb[$];
  logic [DW-1:0] exp_mem [0:15];

  // Refresh burst monitor with an independent row-pointer model.
  int          burst_len = 0;
  int          burst_cnt = 0;
  int          burst_start = 0;
  int          prev_start = 0;
  logic [AW-1:0] burst_addr = '0;
  logic [AW-1:0] exp_row = '0;
  bit          have_prev = 1'b0;
  bit          check_interval = 1'b0;

  always @(negedge clk) begin
    if (reset) begin
      burst_len <= 0;
      exp_row   <= '0;
    end else begin
      if (bus.mem_en || bus.mem_refresh) chk("en_refresh_excl", bus.mem_en & bus.mem_refresh, 0);
      if (bus.mem_refresh) begin
        if (burst_len == 0) begin
          burst_addr  <= bus.mem_addr;
          burst_start <= cyc;
        end else begin
          chk("burst_addr_stable", bus.mem_addr, burst_addr);
        end
        burst_len <= burst_len + 1;
      end else if (burst_len > 0) begin
        chk("burst_len", burst_len, RC);
        chk("burst_row", burst_addr, exp_row);
        if (check_interval && have_prev) chk("burst_interval", burst_start - prev_start, DIV_PERIOD);
        prev_start <= burst_start;
        have_prev  <= check_interval;
        exp_row    <= (exp_row == AW'(ROWS - 1)) ? '0 : exp_row + 1'b1;
        burst_cnt  <= burst_cnt + 1;
        burst_len  <= 0;
      end
      if (bus.rsp_valid) begin
        if (sb.size() == 0) begin
          chk("rsp_unexpected", bus.rsp_valid, 0);
        end else begin
          chk("rsp_rdata", bus.rsp_rdata, sb[0].data);
          chk("rsp_latency", cyc, sb[0].cyc);
          void'(sb.pop_front());
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Issue one request and check the ACCESS cycle it produces. Returns in the
  // cycle after ACCESS (RD_WAIT for reads, IDLE for writes).
  task automatic send(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    int n = 0;
    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_addr  = a;
    bus.req_wdata = d;
    while (!bus.req_ready && n < 1000) begin
      tick(1);
      n++;
    end
    chk("req_ready_wait", bus.req_ready, 1);
    tick(1);
    bus.req_valid = 1'b0;
    chk("acc_mem_en", bus.mem_en, 1);
    chk("acc_mem_we", bus.mem_we, wr);
    chk("acc_mem_addr", bus.mem_addr, a);
    if (wr) begin
      chk("acc_mem_wdata", bus.mem_wdata, d);
      exp_mem[a] = d;
    end else begin
      // ACCESS is the cycle after the accepting edge; response two later.
      sb.push_back('{exp_mem[a], cyc + 2});
    end
    tick(1);
    chk("mem_en_one_cycle", bus.mem_en, 0);
  endtask

  task automatic rise_refresh();
    man_clk = 1'b0;
    tick(1);
    man_clk = 1'b1;
    tick(1);
  endtask

  initial begin
    int n;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;

    // Reset held 20 cycles with refresh_clk high.
    tick(20);
    chk("reset_outputs", outs(), 0);
    enabled = 1'b0;
    reset   = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      chk("post_reset_outputs", outs(), 0);
    end
    enabled = 1'b1;
    tick(1);
    chk("ready_when_enabled", bus.req_ready, 1);
    chk("no_false_refresh", bus.mem_refresh, 0);

    // Write then read back, plus a second address.
    send(1'b1, 4'd5, 16'hA5A5);
    send(1'b0, 4'd5, 16'h0000);
    tick(3);
    chk("rsp_drained_1", sb.size(), 0);
    send(1'b1, 4'd15, 16'h1234);
    send(1'b0, 4'd15, 16'h0000);
    send(1'b0, 4'd5, 16'h0000);
    tick(4);

    // Divider-driven refresh: 17 bursts, last one wraps to row 0.
    check_interval = 1'b1;
    div_en = 1'b1;
    n = 0;
    while (burst_cnt < 17 && n < 6000) begin
      tick(1);
      n++;
    end
    chk("div_burst_count", burst_cnt, 17);
    chk("wrap_row", burst_addr, 0);
    check_interval = 1'b0;
    div_en = 1'b0;
    tick(2);

    // Refresh pending while a request waits: refresh first, then request.
    rise_refresh();
    bus.req_valid = 1'b1;
    bus.req_write = 1'b0;
    bus.req_addr  = 4'd5;
    chk("prio_ready_low", bus.req_ready, 0);
    for (int i = 0; i < RC; i++) begin
      tick(1);
      chk("prio_refresh", bus.mem_refresh, 1);
      chk("prio_ready_refresh", bus.req_ready, 0);
      chk("prio_row", bus.mem_addr, 1);
    end
    tick(1);
    chk("prio_ready_after", bus.req_ready, 1);
    send(1'b0, 4'd5, 16'h0000);
    tick(3);
    chk("rsp_drained_2", sb.size(), 0);

    // Rise while disabled is discarded.
    enabled = 1'b0;
    rise_refresh();
    enabled = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick(1);
      chk("disabled_rise_ignored", bus.mem_refresh, 0);
    end

    // Two further rises during a refresh burst -> overrun.
    chk("no_overrun_yet", refresh_overrun, 0);
    rise_refresh();
    tick(1);
    chk("ovr_in_refresh", bus.mem_refresh, 1);
    man_clk = 1'b0;
    tick(1);
    man_clk = 1'b1;
    tick(1);
    man_clk = 1'b0;
    chk("ovr_not_yet", refresh_overrun, 0);
    tick(1);
    man_clk = 1'b1;
    chk("ovr_not_yet_2", refresh_overrun, 0);
    tick(1);
    chk("ovr_set", refresh_overrun, 1);
    tick(8);
    chk("ovr_sticky", refresh_overrun, 1);

    // Reset during RD_WAIT: no response, everything cleared.
    send(1'b0, 4'd5, 16'h0000);
    reset = 1'b1;
    sb.delete();
    tick(1);
    chk("rst_rdwait_rsp", bus.rsp_valid, 0);
    chk("rst_rdwait_outputs", outs(), 0);
    reset = 1'b0;
    tick(2);
    chk("rst_rdwait_no_rsp", bus.rsp_valid, 0);

    // Reset during the second refresh cycle.
    rise_refresh();
    tick(2);
    chk("rst_ref_cycle2", bus.mem_refresh, 1);
    chk("rst_ref_row0", bus.mem_addr, 0);
    reset = 1'b1;
    tick(1);
    chk("rst_ref_outputs", outs(), 0);
    reset = 1'b0;
    tick(1);
    rise_refresh();
    tick(1);
    chk("row_after_reset", bus.mem_addr, 0);
    tick(6);
    chk("final_sb_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_mem_refresh_ctrl
`default_nettype wire
